// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the UART baud-rate training controller.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    HUNT_IDLE,
    WAIT_FALL,
    MEASURE,
    SETTLE,
    LOCKED
  } state_t;

  localparam int SYNC_EDGES     = 5;
  localparam int ROUND_ADD      = 32;
  localparam int PRESCALE_SHIFT = 6;
  localparam int TOL_SHIFT      = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture; both flops come out of reset at the idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_autobaud.sv
// Baud-rate training: measures a 0x55 sync byte, derives the receiver
// prescale (bit period = prescale*8 clocks), gates rxd until locked and
// re-trains after repeated frame errors.
//
// state     | meaning
// HUNT_IDLE | waiting for IDLE_MIN continuous high cycles
// WAIT_FALL | line idle, waiting for the start-bit falling edge
// MEASURE   | timing the four falling-edge intervals of the sync byte
// SETTLE    | waiting for the line to return high after the sync byte
// LOCKED    | prescale valid, receiver sees the line, counting errors
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int          CNT_WIDTH        = 24,
  parameter logic [15:0] PRESCALE_DEFAULT = 16'd1,
  parameter int          MIN_COUNT        = 64,
  parameter int          ERR_LIMIT        = 4,
  parameter int          IDLE_MIN         = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        relock,
  input  logic        frame_error_in,
  input  logic        byte_valid_in,
  output logic        rxd_out,
  output logic [15:0] prescale,
  output logic        locked,
  output logic        lock_fail,
  output logic        lock_lost
);

  localparam int IW     = CNT_WIDTH - 2;
  localparam int IDLE_W = $clog2(IDLE_MIN + 1);
  localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
  localparam int EDGE_W = $clog2(SYNC_EDGES);

  state_t              state, state_nxt;
  logic                rxd_sync, rxd_dly, fall;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [IW-1:0]       int_cnt, i0;
  logic [CNT_WIDTH-1:0] acc, c_new;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [ERR_W-1:0]    err_cnt;
  logic [IW:0]         ik, tol, lim, dev;
  logic [CNT_WIDTH:0]  rounded, scaled;
  logic [15:0]         prescale_calc;
  logic                meas_abort, meas_done, err_hit;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_sync)
  );

  assign fall    = rxd_dly & ~rxd_sync;
  assign rxd_out = locked ? rxd_sync : 1'b1;

  // delayed copy of the synchronized line for edge detection
  always_ff @(posedge clk) begin
    if (rst) rxd_dly <= 1'b1;
    else     rxd_dly <= rxd_sync;
  end

  // interval arithmetic: current interval length, tolerance window, new total and rounded prescale
  always_comb begin
    ik            = {1'b0, int_cnt} + (IW+1)'(1);
    tol           = {1'b0, i0 >> TOL_SHIFT};
    lim           = {1'b0, i0} + tol;
    dev           = (ik > {1'b0, i0}) ? (ik - {1'b0, i0}) : ({1'b0, i0} - ik);
    c_new         = acc + CNT_WIDTH'(ik);
    rounded       = {1'b0, c_new} + (CNT_WIDTH+1)'(ROUND_ADD);
    scaled        = rounded >> PRESCALE_SHIFT;
    prescale_calc = (|scaled[CNT_WIDTH:16]) ? 16'hFFFF : scaled[15:0];
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode and per-cycle measurement verdicts; relock overrides everything
  always_comb begin
    state_nxt  = state;
    meas_abort = 1'b0;
    meas_done  = 1'b0;
    err_hit    = 1'b0;
    case (state)
      HUNT_IDLE: if (idle_cnt == IDLE_W'(IDLE_MIN)) state_nxt = WAIT_FALL;
      WAIT_FALL: if (fall) state_nxt = MEASURE;
      MEASURE: begin
        if (&int_cnt) meas_abort = 1'b1;
        else if ((edge_cnt != '0) && (ik > lim)) meas_abort = 1'b1;
        else if (fall) begin
          if ((edge_cnt != '0) && (dev > tol)) meas_abort = 1'b1;
          else if (edge_cnt == EDGE_W'(SYNC_EDGES - 2)) begin
            if (c_new < CNT_WIDTH'(MIN_COUNT)) meas_abort = 1'b1;
            else                               meas_done  = 1'b1;
          end
        end
        if (meas_abort)     state_nxt = HUNT_IDLE;
        else if (meas_done) state_nxt = SETTLE;
      end
      SETTLE: if (rxd_sync) state_nxt = LOCKED;
      LOCKED: begin
        if (frame_error_in && (err_cnt == ERR_W'(ERR_LIMIT - 1))) begin
          err_hit   = 1'b1;
          state_nxt = HUNT_IDLE;
        end
      end
      default: state_nxt = HUNT_IDLE;
    endcase
    if (relock) begin
      state_nxt  = HUNT_IDLE;
      meas_abort = 1'b0;
      meas_done  = 1'b0;
      err_hit    = 1'b0;
    end
  end

  // consecutive-idle counter, only live while hunting
  always_ff @(posedge clk) begin
    if (rst || relock || (state != HUNT_IDLE) || !rxd_sync) idle_cnt <= '0;
    else                                                   idle_cnt <= idle_cnt + 1'b1;
  end

  // measurement datapath, lock flag, error counter and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      int_cnt   <= '0;
      i0        <= '0;
      acc       <= '0;
      edge_cnt  <= '0;
      err_cnt   <= '0;
      prescale  <= PRESCALE_DEFAULT;
      locked    <= 1'b0;
      lock_fail <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_fail <= 1'b0;
      lock_lost <= 1'b0;
      if (relock) begin
        locked  <= 1'b0;
        err_cnt <= '0;
      end else begin
        case (state)
          WAIT_FALL: begin
            if (fall) begin
              int_cnt  <= '0;
              edge_cnt <= '0;
              acc      <= '0;
            end
          end
          MEASURE: begin
            int_cnt <= int_cnt + 1'b1;
            if (meas_abort) lock_fail <= 1'b1;
            else if (fall) begin
              int_cnt  <= '0;
              edge_cnt <= edge_cnt + 1'b1;
              acc      <= c_new;
              if (edge_cnt == '0) i0 <= ik[IW-1:0];
              if (meas_done) prescale <= prescale_calc;
            end
          end
          SETTLE: begin
            err_cnt <= '0;
            if (rxd_sync) locked <= 1'b1;
          end
          LOCKED: begin
            if (err_hit) begin
              lock_lost <= 1'b1;
              locked    <= 1'b0;
              err_cnt   <= '0;
            end else if (frame_error_in) err_cnt <= err_cnt + 1'b1;
            else if (byte_valid_in)      err_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_autobaud.md
Name: uart_autobaud

Overview:
Baud-rate training controller for the AXI-stream UART receiver. It measures a 0x55 sync character on the raw rxd line and computes the receiver's 16-bit prescale value, where bit period = prescale×8 clk cycles. It gates the receiver's rxd input until lock is achieved. It monitors receiver frame errors and re-trains automatically after repeated errors.

Parameters:
CNT_WIDTH, 24, width of total-measurement accumulator; interval counters are CNT_WIDTH-2 bits
PRESCALE_DEFAULT, 16'd1, prescale value driven out of reset
MIN_COUNT, 64, minimum accepted total count C (guarantees prescale ≥ 1)
ERR_LIMIT, 4, consecutive frame errors in LOCKED that trigger re-training
IDLE_MIN, 256, continuous high cycles on synchronized rxd required before hunting for a start edge

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rxd  in  1  raw asynchronous serial line
relock  in  1  single-cycle request to discard lock and re-train
frame_error_in  in  1  frame-error pulse from the receiver
byte_valid_in  in  1  good-byte pulse from the receiver (tvalid&tready)
rxd_out  out  1  line to the receiver: rxd_sync when locked=1, else constant 1
prescale  out  16  prescale value for the receiver
locked  out  1  training complete, prescale valid
lock_fail  out  1  one-cycle pulse: training attempt aborted
lock_lost  out  1  one-cycle pulse: ERR_LIMIT reached in LOCKED

Behaviour:
- Reset state: prescale=PRESCALE_DEFAULT, locked=0, rxd_out=1, lock_fail=0, lock_lost=0, FSM=HUNT_IDLE, all counters 0. The synchronizer flops reset to 1.
- rxd passes through a 2-flop synchronizer (rxd_sync). All edge detection uses rxd_sync and its 1-cycle-delayed copy, so detection latency is 3 cycles from the raw edge.
- HUNT_IDLE: counts consecutive rxd_sync=1 cycles and clears the count on 0. Reaching IDLE_MIN moves to WAIT_FALL.
- WAIT_FALL: on the first falling edge, clear the interval counter and edge count, then move to MEASURE.
- MEASURE: the interval counter increments every cycle. A 0x55 sync byte (sent LSB first) produces falling edges at 0, 2T, 4T, 6T and 8T.
  - On each falling edge, record interval Ik, add it to C and reset the interval counter.
  - I0 (the first interval) is stored as the reference value.
  - For k≥1, abort if |Ik−I0| > I0>>2.
  - Abort if, for k≥1, the running interval exceeds I0+(I0>>2), or if the interval counter saturates.
  - After the 4th interval (5th edge): if C < MIN_COUNT, abort. Otherwise prescale ← min((C+32)>>6, 16'hFFFF), registered and visible the next cycle. Then move to SETTLE.
- Any abort: lock_fail pulses for one cycle and the FSM returns to HUNT_IDLE. prescale keeps its previous value.
- SETTLE: waits for rxd_sync=1. locked rises on the next cycle and the FSM moves to LOCKED. This prevents the receiver from seeing the tail of the sync byte.
- LOCKED:
  - frame_error_in increments err_cnt; byte_valid_in clears it. If both occur in the same cycle, the error wins.
  - When err_cnt reaches ERR_LIMIT: lock_lost pulses, locked←0, err_cnt←0, FSM←HUNT_IDLE.
- relock: from any state, takes priority over all other events. Sets locked←0, err_cnt←0, FSM←HUNT_IDLE. No pulse outputs. prescale is retained.
- rst asserted mid-measurement: returns to the full reset state on the next edge.
- rxd_out is derived combinationally from registered locked and rxd_sync.

Decomposition:
- Package uart_autobaud_pkg holds:
  - FSM state encoding: HUNT_IDLE, WAIT_FALL, MEASURE, SETTLE, LOCKED.
  - localparams SYNC_EDGES=5, ROUND_ADD=32, PRESCALE_SHIFT=6, TOL_SHIFT=2.
- One sub-module: sync_2ff, a generic 2-flop synchronizer with a reset value parameter. It is reused by other async inputs.

Test Plan:
- 0x55 at T=868 cycles after ≥256 idle cycles -> C=6944, prescale=109, lock_fail=0, locked=1 after the stop bit; rxd_out=1 until locked.
- 0x55 at T=10417 -> C=83336, prescale=1302; a following byte 0xA3 decodes correctly in the receiver.
- 0x55 with the 3rd interval stretched by 30% -> lock_fail pulses once, locked stays 0, prescale unchanged, FSM hunts again.
- In LOCKED, 3 frame errors, 1 byte_valid, then 4 frame errors -> lock_lost pulses exactly on the 4th consecutive error and locked=0 the next cycle; a frame error coincident with byte_valid counts as an error.
- relock asserted mid-MEASURE and in LOCKED -> locked=0, no pulses, prescale retained; re-training with T=868 relocks to 109.
- Start edge with <256 idle cycles before it, or T=4 (C=32<64) -> no lock; the former is never measured, the latter produces lock_fail.
